// File: rtl/data_mem_responder.sv
// Latency-parameterised 64-bit doubleword data memory behind valid/ready request and response channels.
// One request is outstanding at a time. Misaligned or out-of-range accesses return an error and are not executed.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        load_ok_q, load_ok_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;

  logic [63:0] mem [DEPTH];
  logic [63:0] mem_rd_q;

  logic          access;
  logic          addr_err;
  logic [AW-1:0] index;

  // Full-width compare so that addresses with high bits set never alias into the array.
  assign addr_err = (addr_q[2:0] != 3'b000) || (addr_q[63:3] >= 61'(DEPTH));
  assign index    = addr_q[AW+2:3];
  assign access   = (state_q == WAIT) && (cnt_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    load_ok_d   = load_ok_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = 4'(LATENCY - 1);
          req_ready_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          err_d       = addr_err;
          load_ok_d   = !addr_err && !write_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          err_d       = 1'b0;
          load_ok_d   = 1'b0;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      err_q       <= 1'b0;
      load_ok_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      load_ok_q   <= load_ok_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Array and read register stay reset-free so the memory maps onto block RAM.
  always_ff @(posedge clk) begin
    if (access) begin
      if (write_q && !addr_err) mem[index] <= wdata_q;
      mem_rd_q <= mem[index];
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = load_ok_q ? mem_rd_q : 64'd0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 3, 1) checked against a word-array reference model.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [63:0] req_addr  [3];
  logic [63:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [63:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] ref_mem [3][256];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      data_mem_responder #(
        .DEPTH  (256),
        .LATENCY(gi == 0 ? 2 : (gi == 1 ? 3 : 1))
      ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid[gi]),
        .req_ready(req_ready[gi]),
        .req_write(req_write[gi]),
        .req_addr (req_addr[gi]),
        .req_wdata(req_wdata[gi]),
        .rsp_valid(rsp_valid[gi]),
        .rsp_ready(rsp_ready[gi]),
        .rsp_rdata(rsp_rdata[gi]),
        .rsp_err  (rsp_err[gi])
      );
    end
  endgenerate

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 3 : 1);
  endfunction

  // Reference: 256 doublewords = 2048 bytes; anything unaligned or beyond is an error.
  function automatic void model(input int d, input bit wr, input logic [63:0] addr,
                                input logic [63:0] wdata, output logic [63:0] rdata,
                                output logic err);
    err   = (addr % 64'd8 != 64'd0) || (addr >= 64'd2048);
    rdata = 64'd0;
    if (!err) begin
      if (wr) ref_mem[d][int'(addr / 64'd8)] = wdata;
      else    rdata = ref_mem[d][int'(addr / 64'd8)];
    end
  endfunction

  // Drives one request; while the response is held back a conflicting store is offered on the request channel.
  task automatic txn(input int d, input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                     input int delay, output logic [63:0] rdata, output logic err, output int lat,
                     output bit ok_ready, output bit ok_hold, output bit ok_post);
    ok_hold = 1'b1;
    ok_post = 1'b0;
    lat     = 0;
    rdata   = 'x;
    err     = 1'bx;
    @(negedge clk);
    ok_ready     = (req_ready[d] === 1'b1);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    rsp_ready[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d]  = {$urandom, $urandom};
    req_wdata[d] = {$urandom, $urandom};
    req_write[d] = 1'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid[d] === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      ok_hold      = 1'b0;
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      return;
    end
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    for (int k = 0; k < delay; k++) begin
      req_valid[d] = 1'b1;
      req_write[d] = 1'b1;
      req_addr[d]  = addr ^ 64'h40;
      req_wdata[d] = {$urandom, $urandom};
      @(negedge clk);
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rdata || rsp_err[d] !== err ||
          req_ready[d] !== 1'b0)
        ok_hold = 1'b0;
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    ok_post      = (rsp_valid[d] === 1'b0) && (req_ready[d] === 1'b1);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = 64'd0;
      req_wdata[d] = 64'd0;
      rsp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]} !== {3'b100, 64'd0}) begin
        miscompares++;
        $display("FAIL reset[%0d]: got ready=%b valid=%b err=%b rdata=%h, expected ready=1 valid=0 err=0 rdata=0",
                 d, req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]);
      end
    end
  endtask

  task automatic test_store_load();
    logic [63:0] rd, erd;
    logic        er, eer;
    int          lat;
    bit          a, h, p;
    bit          wr_t   [2] = '{1'b1, 1'b0};
    logic [63:0] addr_t [2] = '{64'h10, 64'h10};
    for (int i = 0; i < 2; i++) begin
      model(0, wr_t[i], addr_t[i], 64'hDEADBEEF_CAFEF00D, erd, eer);
      txn(0, wr_t[i], addr_t[i], 64'hDEADBEEF_CAFEF00D, 0, rd, er, lat, a, h, p);
      vectors++;
      if ({er, rd} !== {eer, erd}) begin
        miscompares++;
        $display("FAIL store_load[%0d] data: got err=%b rdata=%h, expected err=%b rdata=%h", i, er, rd, eer, erd);
      end
      vectors++;
      if (lat != 2 || !a || !h || !p) begin
        miscompares++;
        $display("FAIL store_load[%0d] timing: got latency=%0d ready=%b hold=%b release=%b, expected latency=2 and all 1",
                 i, lat, a, h, p);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd, erd;
    logic        er, eer;
    int          lat;
    bit          a, h, p;
    model(0, 1'b0, 64'h10, 64'd0, erd, eer);
    txn(0, 1'b0, 64'h10, 64'd0, 5, rd, er, lat, a, h, p);
    vectors++;
    if ({er, rd} !== {eer, erd}) begin
      miscompares++;
      $display("FAIL backpressure data: got err=%b rdata=%h, expected err=%b rdata=%h", er, rd, eer, erd);
    end
    vectors++;
    if (lat != 2 || !a || !h || !p) begin
      miscompares++;
      $display("FAIL backpressure hold: got latency=%0d ready=%b hold=%b release=%b, expected latency=2 and all 1",
               lat, a, h, p);
    end
  endtask

  task automatic test_errors();
    logic [63:0] rd, erd;
    logic        er, eer;
    int          lat;
    bit          a, h, p;
    bit          wr_t   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] addr_t [8] = '{64'h13, 64'h10, 64'h800, 64'h8000_0000_0000_0010,
                                64'h8000_0000_0000_0010, 64'h10, 64'h7F8, 64'h7F8};
    for (int i = 0; i < 8; i++) begin
      logic [63:0] wd;
      wd = {$urandom, $urandom};
      model(0, wr_t[i], addr_t[i], wd, erd, eer);
      txn(0, wr_t[i], addr_t[i], wd, int'($urandom_range(0, 2)), rd, er, lat, a, h, p);
      vectors++;
      if ({er, rd} !== {eer, erd}) begin
        miscompares++;
        $display("FAIL errors[%0d] addr=%h: got err=%b rdata=%h, expected err=%b rdata=%h",
                 i, addr_t[i], er, rd, eer, erd);
      end
      vectors++;
      if (lat != 2 || !a || !h || !p) begin
        miscompares++;
        $display("FAIL errors[%0d] timing: got latency=%0d ready=%b hold=%b release=%b, expected latency=2 and all 1",
                 i, lat, a, h, p);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [63:0] rd, erd;
    logic        er, eer;
    int          lat;
    bit          a, h, p, quiet;
    model(1, 1'b1, 64'h20, 64'h5, erd, eer);
    txn(1, 1'b1, 64'h20, 64'h5, 0, rd, er, lat, a, h, p);
    vectors++;
    if ({er, rd} !== {eer, erd} || lat != 3 || !a || !h || !p) begin
      miscompares++;
      $display("FAIL midop_setup: got err=%b rdata=%h latency=%0d flags=%b%b%b, expected err=0 rdata=0 latency=3 flags=111",
               er, rd, lat, a, h, p);
    end
    // Store of 0x1 is accepted, then reset lands two edges before its access edge.
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 64'h20;
    req_wdata[1] = 64'h1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) quiet = 1'b0;
    end
    reset        = 1'b1;
    rsp_ready[1] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) quiet = 1'b0;
    end
    rsp_ready[1] = 1'b0;
    vectors++;
    if (!quiet) begin
      miscompares++;
      $display("FAIL midop_quiet: got a response or busy after reset, expected rsp_valid=0 req_ready=1");
    end
    model(1, 1'b0, 64'h20, 64'd0, erd, eer);
    txn(1, 1'b0, 64'h20, 64'd0, 0, rd, er, lat, a, h, p);
    vectors++;
    if ({er, rd} !== {eer, erd}) begin
      miscompares++;
      $display("FAIL midop_readback: got err=%b rdata=%h, expected err=%b rdata=%h", er, rd, eer, erd);
    end
    vectors++;
    if (lat != 3 || !a || !h || !p) begin
      miscompares++;
      $display("FAIL midop_timing: got latency=%0d ready=%b hold=%b release=%b, expected latency=3 and all 1",
               lat, a, h, p);
    end
  endtask

  task automatic test_latency1_sweep();
    logic [63:0] rd, erd, wd, addr;
    logic        er, eer;
    int          lat;
    bit          a, h, p;
    for (int i = 0; i < 100; i++) begin
      addr = 64'(8 * $urandom_range(0, 255));
      wd   = {$urandom, $urandom};
      for (int j = 0; j < 2; j++) begin
        model(2, (j == 0), addr, wd, erd, eer);
        txn(2, (j == 0), addr, wd, int'($urandom_range(0, 3)), rd, er, lat, a, h, p);
        vectors++;
        if ({er, rd} !== {eer, erd}) begin
          miscompares++;
          $display("FAIL sweep[%0d.%0d] addr=%h: got err=%b rdata=%h, expected err=%b rdata=%h",
                   i, j, addr, er, rd, eer, erd);
        end
        vectors++;
        if (lat != lat_of(2) || !a || !h || !p) begin
          miscompares++;
          $display("FAIL sweep[%0d.%0d] timing: got latency=%0d ready=%b hold=%b release=%b, expected latency=1 and all 1",
                   i, j, lat, a, h, p);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_store_load();
    test_backpressure();
    test_errors();
    test_reset_midop();
    test_latency1_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
